// File: rtl/sp_link_ctrl.sv
// Link synchronization controller: slips bit alignment until BC commas lock, then forwards payload.
// Optional statistics counters are enabled with `define SP_LINK_CTRL_STATS_EN.
module sp_link_ctrl #(
  parameter logic [7:0] BC_CODE     = 8'hBC,
  parameter int         LOCK_COUNT  = 4,
  parameter int         SLIP_WAIT   = 8,
  parameter int         SLIP_SETTLE = 2,
  parameter int         MAX_GAP     = 64
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] parallel_in,
  output logic       bit_slip,
  output logic       locked,
  output logic       lost,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic [1:0] state_out,
  output logic [7:0] lock_events,
  output logic [7:0] loss_events
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_SLIP    = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // Terminal values: each counter stops one short of its parameter and acts on that byte.
  localparam logic [7:0] LP_WAIT_LAST   = 8'(SLIP_WAIT - 1);
  localparam logic [3:0] LP_SETTLE_LAST = 4'(SLIP_SETTLE - 1);
  localparam logic [3:0] LP_BC_LAST     = 4'(LOCK_COUNT - 1);
  localparam logic [7:0] LP_GAP_LAST    = 8'(MAX_GAP - 1);

  state_t     r_state, w_nxt_state;
  logic [7:0] r_wait_cnt, w_nxt_wait_cnt;
  logic [3:0] r_bc_cnt, w_nxt_bc_cnt;
  logic [3:0] r_settle_cnt, w_nxt_settle_cnt;
  logic [7:0] r_gap_cnt, w_nxt_gap_cnt;
  logic       r_bit_slip, w_nxt_bit_slip;
  logic       r_locked;
  logic       r_lost, w_nxt_lost;
  logic       r_valid_out, w_nxt_valid_out;
  logic [7:0] r_data_out, w_nxt_data_out;
  logic       w_lock_evt;
  logic       w_is_comma;

  assign w_is_comma = (parallel_in == BC_CODE);

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_wait_cnt   = r_wait_cnt;
    w_nxt_bc_cnt     = r_bc_cnt;
    w_nxt_settle_cnt = r_settle_cnt;
    w_nxt_gap_cnt    = r_gap_cnt;
    w_nxt_bit_slip   = 1'b0;
    w_nxt_lost       = 1'b0;
    w_nxt_valid_out  = 1'b0;
    w_nxt_data_out   = r_data_out;
    w_lock_evt       = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (in_valid) begin
          if (w_is_comma) begin
            w_nxt_state    = ST_CONFIRM;
            w_nxt_bc_cnt   = 4'd1;
            w_nxt_wait_cnt = 8'd0;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            w_nxt_state    = ST_SLIP;
            w_nxt_bit_slip = 1'b1;
            w_nxt_wait_cnt = 8'd0;
          end else begin
            w_nxt_wait_cnt = r_wait_cnt + 8'd1;
          end
        end
      end
      // Settle countdown runs on every cycle, independent of in_valid.
      ST_SLIP: begin
        if (r_settle_cnt == LP_SETTLE_LAST) begin
          w_nxt_state      = ST_HUNT;
          w_nxt_settle_cnt = 4'd0;
        end else begin
          w_nxt_settle_cnt = r_settle_cnt + 4'd1;
        end
      end
      ST_CONFIRM: begin
        if (in_valid) begin
          if (!w_is_comma) begin
            w_nxt_state    = ST_HUNT;
            w_nxt_bc_cnt   = 4'd0;
            w_nxt_wait_cnt = 8'd0;
          end else if (r_bc_cnt == LP_BC_LAST) begin
            w_nxt_state   = ST_LOCKED;
            w_nxt_bc_cnt  = 4'd0;
            w_nxt_gap_cnt = 8'd0;
            w_lock_evt    = 1'b1;
          end else begin
            w_nxt_bc_cnt = r_bc_cnt + 4'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (in_valid) begin
          if (w_is_comma) begin
            w_nxt_gap_cnt = 8'd0;
          end else begin
            w_nxt_valid_out = 1'b1;
            w_nxt_data_out  = parallel_in;
            if (r_gap_cnt == LP_GAP_LAST) begin
              w_nxt_state   = ST_HUNT;
              w_nxt_gap_cnt = 8'd0;
              w_nxt_lost    = 1'b1;
            end else begin
              w_nxt_gap_cnt = r_gap_cnt + 8'd1;
            end
          end
        end
      end
      default: w_nxt_state = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_HUNT;
      r_wait_cnt   <= 8'd0;
      r_bc_cnt     <= 4'd0;
      r_settle_cnt <= 4'd0;
      r_gap_cnt    <= 8'd0;
      r_bit_slip   <= 1'b0;
      r_locked     <= 1'b0;
      r_lost       <= 1'b0;
      r_valid_out  <= 1'b0;
      r_data_out   <= 8'h00;
    end else begin
      r_state      <= w_nxt_state;
      r_wait_cnt   <= w_nxt_wait_cnt;
      r_bc_cnt     <= w_nxt_bc_cnt;
      r_settle_cnt <= w_nxt_settle_cnt;
      r_gap_cnt    <= w_nxt_gap_cnt;
      r_bit_slip   <= w_nxt_bit_slip;
      r_locked     <= (w_nxt_state == ST_LOCKED);
      r_lost       <= w_nxt_lost;
      r_valid_out  <= w_nxt_valid_out;
      r_data_out   <= w_nxt_data_out;
    end
  end

`ifdef SP_LINK_CTRL_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  logic [7:0] r_lock_events, r_loss_events;

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_lock_events <= 8'h00;
      r_loss_events <= 8'h00;
    end else begin
      if (w_lock_evt) r_lock_events <= sat_inc8(r_lock_events);
      if (w_nxt_lost) r_loss_events <= sat_inc8(r_loss_events);
    end
  end

  assign lock_events = r_lock_events;
  assign loss_events = r_loss_events;
`else
  logic w_unused_evt;
  assign w_unused_evt = w_lock_evt;
  assign lock_events  = 8'h00;
  assign loss_events  = 8'h00;
`endif

  assign bit_slip  = r_bit_slip;
  assign locked    = r_locked;
  assign lost      = r_lost;
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign state_out = r_state;

endmodule

// File: tb/tb_sp_link_ctrl.sv
// Directed bench for sp_link_ctrl: lock, slip cadence, broken confirm, gap loss, stalls, mid-stream reset.
module tb_sp_link_ctrl;

`ifdef SP_LINK_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk_f = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] parallel_in = 8'h00;
  logic       bit_slip, locked, lost, valid_out;
  logic [7:0] data_out, lock_events, loss_events;
  logic [1:0] state_out;

  int n_vec  = 0;
  int n_miss = 0;
  int fwd    = 0;

  sp_link_ctrl dut (
    .clk_f       (clk_f),
    .reset       (reset),
    .in_valid    (in_valid),
    .parallel_in (parallel_in),
    .bit_slip    (bit_slip),
    .locked      (locked),
    .lost        (lost),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .state_out   (state_out),
    .lock_events (lock_events),
    .loss_events (loss_events)
  );

  always #5 clk_f = ~clk_f;

  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk_f);
    in_valid    = v;
    parallel_in = b;
    @(posedge clk_f);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %02h, expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] stat(input int n);
    return STATS ? 8'(n) : 8'h00;
  endfunction

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clk_f);
    #1;
    chk("rst_state", {6'd0, state_out}, 8'd0);
    chk("rst_locked", {7'd0, locked}, 8'd0);
    chk("rst_valid", {7'd0, valid_out}, 8'd0);
    chk("rst_slip", {7'd0, bit_slip}, 8'd0);
    chk("rst_lost", {7'd0, lost}, 8'd0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_lockev", lock_events, 8'h00);
    chk("rst_lossev", loss_events, 8'h00);
    @(negedge clk_f);
    reset = 1'b1;

    // Clean lock
    step(1'b1, 8'hBC);
    chk("cl_state1", {6'd0, state_out}, 8'd2);
    step(1'b1, 8'hBC);
    step(1'b1, 8'hBC);
    chk("cl_locked3", {7'd0, locked}, 8'd0);
    step(1'b1, 8'hBC);
    chk("cl_locked4", {7'd0, locked}, 8'd1);
    chk("cl_state4", {6'd0, state_out}, 8'd3);
    chk("cl_valid4", {7'd0, valid_out}, 8'd0);
    chk("cl_lockev", lock_events, stat(1));
    step(1'b1, 8'h12);
    chk("cl_v12", {7'd0, valid_out}, 8'd1);
    chk("cl_d12", data_out, 8'h12);
    step(1'b1, 8'h34);
    chk("cl_v34", {7'd0, valid_out}, 8'd1);
    chk("cl_d34", data_out, 8'h34);
    step(1'b1, 8'hBC);
    chk("cl_vbc", {7'd0, valid_out}, 8'd0);

    // Gap: comma at byte 63 keeps lock, then 64 payload bytes lose it
    fwd = 0;
    for (int i = 1; i <= 62; i++) begin
      step(1'b1, 8'h01);
      if (valid_out && data_out == 8'h01) fwd++;
    end
    step(1'b1, 8'hBC);
    chk("gap63_locked", {7'd0, locked}, 8'd1);
    chk("gap63_fwd", 8'(fwd), 8'd62);
    fwd = 0;
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 8'h01);
      if (valid_out && data_out == 8'h01) fwd++;
      if (i == 63) begin
        chk("gap_locked63", {7'd0, locked}, 8'd1);
        chk("gap_lost63", {7'd0, lost}, 8'd0);
      end
    end
    chk("gap_fwd64", 8'(fwd), 8'd64);
    chk("gap_lost", {7'd0, lost}, 8'd1);
    chk("gap_locked", {7'd0, locked}, 8'd0);
    chk("gap_state", {6'd0, state_out}, 8'd0);
    chk("gap_lossev", loss_events, stat(1));
    step(1'b0, 8'h01);
    chk("gap_lost_end", {7'd0, lost}, 8'd0);
    chk("gap_valid_end", {7'd0, valid_out}, 8'd0);

    // Misaligned: slips after the 8th byte and 10 cycles later; commas during settle are ignored
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, (i >= 19) ? 8'hBC : 8'h5E);
      chk($sformatf("mis_slip%0d", i), {7'd0, bit_slip}, (i == 8 || i == 18) ? 8'd1 : 8'd0);
      chk($sformatf("mis_state%0d", i), {6'd0, state_out},
          (i == 8 || i == 9 || i == 18 || i == 19) ? 8'd1 : 8'd0);
    end
    for (int i = 1; i <= 4; i++) step(1'b1, 8'hBC);
    chk("mis_locked", {7'd0, locked}, 8'd1);
    chk("mis_lockev", lock_events, stat(2));

    // Idle stripping and stalls
    step(1'b1, 8'h77);
    chk("st_v1", {7'd0, valid_out}, 8'd1);
    chk("st_d1", data_out, 8'h77);
    step(1'b0, 8'h55);
    chk("st_v2", {7'd0, valid_out}, 8'd0);
    chk("st_d2", data_out, 8'h77);
    step(1'b1, 8'hBC);
    chk("st_v3", {7'd0, valid_out}, 8'd0);
    chk("st_d3", data_out, 8'h77);
    step(1'b0, 8'hBC);
    chk("st_v4", {7'd0, valid_out}, 8'd0);
    step(1'b1, 8'h78);
    chk("st_v5", {7'd0, valid_out}, 8'd1);
    chk("st_d5", data_out, 8'h78);
    step(1'b0, 8'h33);
    chk("st_d6", data_out, 8'h78);
    chk("st_locked", {7'd0, locked}, 8'd1);

    // Reset mid-stream
    step(1'b1, 8'h99);
    chk("mr_v", {7'd0, valid_out}, 8'd1);
    in_valid    = 1'b1;
    parallel_in = 8'h42;
    #3 reset = 1'b0;
    #1;
    chk("mr_valid", {7'd0, valid_out}, 8'd0);
    chk("mr_locked", {7'd0, locked}, 8'd0);
    chk("mr_data", data_out, 8'h00);
    chk("mr_lost", {7'd0, lost}, 8'd0);
    chk("mr_state", {6'd0, state_out}, 8'd0);
    chk("mr_lockev", lock_events, 8'h00);
    chk("mr_lossev", loss_events, 8'h00);
    @(posedge clk_f);
    #1;
    chk("mr_lost_hold", {7'd0, lost}, 8'd0);
    @(negedge clk_f);
    reset = 1'b1;

    // Broken confirm: AA drops to HUNT without a slip, then relock
    step(1'b1, 8'hBC);
    step(1'b1, 8'hBC);
    chk("bc_state2", {6'd0, state_out}, 8'd2);
    step(1'b1, 8'hAA);
    chk("bc_state_aa", {6'd0, state_out}, 8'd0);
    chk("bc_slip_aa", {7'd0, bit_slip}, 8'd0);
    step(1'b1, 8'hBC);
    step(1'b1, 8'hBC);
    step(1'b1, 8'hBC);
    chk("bc_locked3", {7'd0, locked}, 8'd0);
    step(1'b1, 8'hBC);
    chk("bc_locked4", {7'd0, locked}, 8'd1);
    chk("bc_lockev", lock_events, stat(1));
    step(1'b1, 8'h5A);
    chk("bc_v", {7'd0, valid_out}, 8'd1);
    chk("bc_d", data_out, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
